// File: rtl/rc4_ksa.sv
// RC4 key-scheduling engine driving an external 256-byte S memory with two-cycle read latency.
// Define RC4_KSA_INIT_FILL_EN to have the engine write the identity permutation into S before scrambling.
module rc4_ksa (
    input  logic        clk,
    input  logic        reset,
    input  logic        sig_start,
    input  logic [23:0] secret_key,
    input  logic [7:0]  mem_out,
    output logic [7:0]  mem_address,
    output logic [7:0]  mem_data,
    output logic        wren,
    output logic        t_done
);

    typedef enum logic [3:0] {
        IDLE,
        FILL,
        READ_SI,
        WAIT_SI,
        CAP_SI,
        CALC_J,
        READ_SJ,
        WAIT_SJ,
        CAP_SJ,
        WR_J,
        WR_J_WAIT,
        WR_I,
        WR_I_WAIT,
        NEXT_I,
        DONE
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [7:0]  i;
    logic [7:0]  j;
    logic [7:0]  si;
    logic [7:0]  sj;
    logic [23:0] key;
    logic [1:0]  i_mod3;
    logic [7:0]  key_byte;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (sig_start) begin
`ifdef RC4_KSA_INIT_FILL_EN
                    next_state = FILL;
`else
                    next_state = READ_SI;
`endif
                end
            end
            FILL:      if (i == 8'hFF) next_state = READ_SI;
            READ_SI:   next_state = WAIT_SI;
            WAIT_SI:   next_state = CAP_SI;
            CAP_SI:    next_state = CALC_J;
            CALC_J:    next_state = READ_SJ;
            READ_SJ:   next_state = WAIT_SJ;
            WAIT_SJ:   next_state = CAP_SJ;
            CAP_SJ:    next_state = WR_J;
            WR_J:      next_state = WR_J_WAIT;
            WR_J_WAIT: next_state = WR_I;
            WR_I:      next_state = WR_I_WAIT;
            WR_I_WAIT: next_state = NEXT_I;
            NEXT_I:    next_state = (i == 8'hFF) ? DONE : READ_SI;
            DONE:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Key bytes are consumed in the order [23:16], [15:8], [7:0], tracked by i_mod3.
    always_comb begin
        case (i_mod3)
            2'd0:    key_byte = key[23:16];
            2'd1:    key_byte = key[15:8];
            default: key_byte = key[7:0];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i      <= 8'd0;
            j      <= 8'd0;
            si     <= 8'd0;
            sj     <= 8'd0;
            key    <= 24'd0;
            i_mod3 <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (sig_start) begin
                        key    <= secret_key;
                        i      <= 8'd0;
                        j      <= 8'd0;
                        i_mod3 <= 2'd0;
                    end
                end
                FILL:   i  <= i + 8'd1;
                CAP_SI: si <= mem_out;
                CALC_J: j  <= j + si + key_byte;
                CAP_SJ: sj <= mem_out;
                NEXT_I: begin
                    if (i != 8'hFF) begin
                        i      <= i + 8'd1;
                        i_mod3 <= (i_mod3 == 2'd2) ? 2'd0 : i_mod3 + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Address and data stay stable through each wait state so the memory sees a clean write.
    always_comb begin
        mem_address = 8'd0;
        mem_data    = 8'd0;
        wren        = 1'b0;
        t_done      = 1'b0;
        case (state)
            FILL: begin
                mem_address = i;
                mem_data    = i;
                wren        = 1'b1;
            end
            READ_SI, WAIT_SI, CAP_SI, CALC_J: mem_address = i;
            READ_SJ, WAIT_SJ, CAP_SJ:         mem_address = j;
            WR_J: begin
                mem_address = j;
                mem_data    = si;
                wren        = 1'b1;
            end
            WR_J_WAIT: begin
                mem_address = j;
                mem_data    = si;
            end
            WR_I: begin
                mem_address = i;
                mem_data    = sj;
                wren        = 1'b1;
            end
            WR_I_WAIT: begin
                mem_address = i;
                mem_data    = sj;
            end
            DONE: t_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rc4_ksa.sv
// Directed bench for rc4_ksa with a two-cycle-latency S memory model and a software KSA reference.
// Builds with or without RC4_KSA_INIT_FILL_EN, matching the design configuration.
module tb_rc4_ksa;

`ifdef RC4_KSA_INIT_FILL_EN
    localparam int EXP_DONE = 3329;
    localparam int FILLW    = 256;
`else
    localparam int EXP_DONE = 3073;
    localparam int FILLW    = 0;
`endif
    localparam int LIMIT = 4000;

    logic        clk;
    logic        reset;
    logic        sig_start;
    logic [23:0] secret_key;
    logic [7:0]  mem_out;
    logic [7:0]  mem_address;
    logic [7:0]  mem_data;
    logic        wren;
    logic        t_done;

    logic [7:0]  mem [256];
    logic [7:0]  rd_addr;
    logic [15:0] wlog [1024];
    int          wcount;
    logic        log_clear;
    logic        preload;
    int          done_pulses;
    int          checks;
    int          failures;
    int          exp_s [256];

    rc4_ksa dut (
        .clk         (clk),
        .reset       (reset),
        .sig_start   (sig_start),
        .secret_key  (secret_key),
        .mem_out     (mem_out),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .wren        (wren),
        .t_done      (t_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // S memory: address registered, then data registered, giving two cycles of read latency.
    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
        end else if (wren) begin
            mem[mem_address] <= mem_data;
        end
        rd_addr <= mem_address;
        mem_out <= mem[rd_addr];
        if (log_clear) begin
            wcount <= 0;
        end else if (wren && wcount < 1024) begin
            wlog[wcount] <= {mem_address, mem_data};
            wcount <= wcount + 1;
        end
    end

    always @(negedge clk) begin
        if (t_done === 1'b1) done_pulses <= done_pulses + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic preloadIdentity();
        @(negedge clk);
        preload = 1'b1;
        @(posedge clk);
        #1 preload = 1'b0;
    endtask

    task automatic applyStimulus(input logic [23:0] key, input bit hold);
        @(negedge clk);
        secret_key = key;
        sig_start  = 1'b1;
        log_clear  = 1'b1;
        @(posedge clk);
        #1;
        log_clear = 1'b0;
        if (!hold) sig_start = 1'b0;
    endtask

    task automatic waitDone(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (t_done !== 1'b1 && cyc < LIMIT);
    endtask

    task automatic computeModel(input logic [23:0] key);
        int jj;
        int kb;
        int tmp;
        for (int k = 0; k < 256; k++) exp_s[k] = k;
        jj = 0;
        for (int k = 0; k < 256; k++) begin
            kb = (k % 3 == 0) ? int'(key[23:16]) : (k % 3 == 1) ? int'(key[15:8]) : int'(key[7:0]);
            jj = (jj + exp_s[k] + kb) % 256;
            tmp = exp_s[k];
            exp_s[k] = exp_s[jj];
            exp_s[jj] = tmp;
        end
    endtask

    task automatic checkFinalS(input string tag, input logic [23:0] key);
        int mism;
        logic [255:0] seen;
        computeModel(key);
        mism = 0;
        seen = '0;
        for (int k = 0; k < 256; k++) begin
            if (int'(mem[k]) != exp_s[k]) mism++;
            seen[mem[k]] = 1'b1;
        end
        checkOutput({tag, "_s_mismatches"}, mism, 0);
        checkOutput({tag, "_permutation"}, {31'd0, &seen}, 1);
    endtask

    initial begin
        int cyc;
        int pulses0;
        int fill_bad;
        checks      = 0;
        failures    = 0;
        done_pulses = 0;
        wcount      = 0;
        log_clear   = 1'b0;
        preload     = 1'b0;
        sig_start   = 1'b0;
        secret_key  = 24'd0;
        reset       = 1'b0;
        #2 reset = 1'b1;
        #3;
        checkOutput("reset_wren", {31'd0, wren}, 0);
        checkOutput("reset_t_done", {31'd0, t_done}, 0);
        checkOutput("reset_mem_address", {24'd0, mem_address}, 0);
        checkOutput("reset_mem_data", {24'd0, mem_data}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Run 1: all-zero key on identity S.
        preloadIdentity();
        pulses0 = done_pulses;
        applyStimulus(24'h000000, 1'b0);
        waitDone(cyc);
        checkOutput("k0_done_cycle", cyc, EXP_DONE);
        repeat (20) @(negedge clk);
        checkOutput("k0_done_pulses", done_pulses - pulses0, 1);
        checkOutput("k0_write_count", wcount, FILLW + 512);
`ifdef RC4_KSA_INIT_FILL_EN
        fill_bad = 0;
        for (int k = 0; k < 256; k++) begin
            if (wlog[k] !== {8'(k), 8'(k)}) fill_bad++;
        end
        checkOutput("fill_sequence_errors", fill_bad, 0);
`endif
        checkOutput("k0_i0_wr_j", {16'd0, wlog[FILLW + 0]}, 32'h0000);
        checkOutput("k0_i0_wr_i", {16'd0, wlog[FILLW + 1]}, 32'h0000);
        checkOutput("k0_i1_wr_j", {16'd0, wlog[FILLW + 2]}, 32'h0101);
        checkOutput("k0_i1_wr_i", {16'd0, wlog[FILLW + 3]}, 32'h0101);
        checkOutput("k0_i2_wr_j", {16'd0, wlog[FILLW + 4]}, 32'h0302);
        checkOutput("k0_i2_wr_i", {16'd0, wlog[FILLW + 5]}, 32'h0203);
        checkFinalS("k0", 24'h000000);

        // Run 2: key 0x010203 with sig_start held high until completion.
        preloadIdentity();
        pulses0 = done_pulses;
        applyStimulus(24'h010203, 1'b1);
        waitDone(cyc);
        sig_start = 1'b0;
        checkOutput("hold_done_cycle", cyc, EXP_DONE);
        repeat (20) @(negedge clk);
        checkOutput("hold_done_pulses", done_pulses - pulses0, 1);
        checkOutput("k123_i0_wr_j", {16'd0, wlog[FILLW + 0]}, 32'h0100);
        checkOutput("k123_i0_wr_i", {16'd0, wlog[FILLW + 1]}, 32'h0001);
        checkOutput("k123_i1_wr_j", {16'd0, wlog[FILLW + 2]}, 32'h0300);
        checkOutput("k123_i1_wr_i", {16'd0, wlog[FILLW + 3]}, 32'h0103);
        checkOutput("k123_i2_wr_j", {16'd0, wlog[FILLW + 4]}, 32'h0802);
        checkOutput("k123_i2_wr_i", {16'd0, wlog[FILLW + 5]}, 32'h0208);
        checkOutput("k123_i3_wr_j", {16'd0, wlog[FILLW + 6]}, 32'h0900);
        checkOutput("k123_i3_wr_i", {16'd0, wlog[FILLW + 7]}, 32'h0309);
        checkFinalS("k123", 24'h010203);

        // Run 3: reset at cycle 1000, then a clean restart with key 0x000249.
        preloadIdentity();
        pulses0 = done_pulses;
        applyStimulus(24'h000249, 1'b0);
        repeat (1000) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("midreset_wren", {31'd0, wren}, 0);
        checkOutput("midreset_t_done", {31'd0, t_done}, 0);
        checkOutput("midreset_mem_address", {24'd0, mem_address}, 0);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midreset_no_done", done_pulses - pulses0, 0);
        preloadIdentity();
        pulses0 = done_pulses;
        applyStimulus(24'h000249, 1'b0);
        waitDone(cyc);
        checkOutput("restart_done_cycle", cyc, EXP_DONE);
        repeat (20) @(negedge clk);
        checkOutput("restart_done_pulses", done_pulses - pulses0, 1);
`ifdef RC4_KSA_INIT_FILL_EN
        checkOutput("restart_first_write", {16'd0, wlog[0]}, 32'h0000);
        checkOutput("restart_second_write", {16'd0, wlog[1]}, 32'h0101);
`else
        checkOutput("restart_first_write", {16'd0, wlog[0]}, 32'h0000);
        checkOutput("restart_second_write", {16'd0, wlog[1]}, 32'h0000);
        checkOutput("restart_third_write", {16'd0, wlog[2]}, 32'h0301);
`endif
        checkFinalS("k249", 24'h000249);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
